// File: rtl/vx_mux_arbiter.sv
// vx_mux_arbiter
// Round-robin arbiter in front of one shared N:1 data multiplexer. Each cycle
// the arbiter picks one valid requester, starting from rr_ptr_r and wrapping
// modulo N. The selected word is captured into a one-entry output register
// that has a valid/ready handshake.
// ready_in depends combinationally on ready_out, so the output register can
// drain and reload in the same cycle. This path is intentional.

module vx_mux_arbiter #(
    parameter  int DATAW = 1,
    parameter  int N     = 1,
    localparam int LN    = $clog2(N),
    localparam int SELW  = (LN > 1) ? LN : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         valid_in,
    input  logic [N*DATAW-1:0]   data_in,
    output logic [N-1:0]         ready_in,
    output logic                 valid_out,
    output logic [DATAW-1:0]     data_out,
    output logic [SELW-1:0]      sel_out,
    input  logic                 ready_out
);

    // Lowest set index of a request vector; the MSB of the result flags "found".
    function automatic logic [SELW:0] find_first(input logic [N-1:0] vec);
        logic [SELW:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, SELW'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic                valid_r;
    logic [DATAW-1:0]    data_r;
    logic [SELW-1:0]     sel_r;
    logic [SELW-1:0]     rr_ptr_r;

    logic                load_en_s;
    logic [N-1:0]        hi_mask_s;
    logic [N-1:0]        masked_s;
    logic [SELW:0]       pick_hi_s;
    logic [SELW:0]       pick_all_s;
    logic                grant_valid_s;
    logic [SELW-1:0]     grant_s;
    logic [N-1:0]        grant_onehot_s;
    logic [DATAW-1:0]    mux_data_s;
    logic [SELW-1:0]     rr_next_s;

    // The register can take a new word when it is empty or draining this cycle.
    always_comb begin
        load_en_s = ~valid_r | ready_out;
    end

    // Mask off requesters below the pointer so the scan starts at rr_ptr_r.
    always_comb begin
        hi_mask_s = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask_s[i] = (SELW'(i) >= rr_ptr_r);
        end
        masked_s = valid_in & hi_mask_s;
    end

    // Use the first valid requester at or above the pointer.
    // If there is none, wrap to the lowest valid requester.
    always_comb begin
        pick_hi_s  = find_first(masked_s);
        pick_all_s = find_first(valid_in);
        if (pick_hi_s[SELW]) begin
            grant_valid_s = 1'b1;
            grant_s       = pick_hi_s[SELW-1:0];
        end else begin
            grant_valid_s = pick_all_s[SELW];
            grant_s       = pick_all_s[SELW-1:0];
        end
    end

    // Decode the grant into a one-hot vector that qualifies the mux and ready_in.
    always_comb begin
        grant_onehot_s = '0;
        for (int i = 0; i < N; i++) begin
            grant_onehot_s[i] = grant_valid_s & (grant_s == SELW'(i));
        end
    end

    // AND-OR data multiplexer selected by the one-hot grant.
    always_comb begin
        mux_data_s = '0;
        for (int i = 0; i < N; i++) begin
            mux_data_s = mux_data_s | (data_in[i*DATAW +: DATAW] & {DATAW{grant_onehot_s[i]}});
        end
    end

    // At most one requester is accepted, and only when the register can load.
    always_comb begin
        ready_in = grant_onehot_s & {N{load_en_s}};
    end

    // The pointer moves past the winner and wraps explicitly so it never reaches N.
    always_comb begin
        if (grant_s == SELW'(N - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_s + SELW'(1);
        end
    end

    // Output register and pointer: load on a transfer, empty when idle, hold under stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r  <= 1'b0;
            data_r   <= '0;
            sel_r    <= '0;
            rr_ptr_r <= '0;
        end else if (load_en_s) begin
            if (grant_valid_s) begin
                valid_r  <= 1'b1;
                data_r   <= mux_data_s;
                sel_r    <= grant_s;
                rr_ptr_r <= rr_next_s;
            end else begin
                valid_r  <= 1'b0;
            end
        end else begin
            valid_r  <= valid_r;
        end
    end

    // Outputs come straight from the output register.
    always_comb begin
        valid_out = valid_r;
        data_out  = data_r;
        sel_out   = sel_r;
    end

endmodule

// File: tb/tb_vx_mux_arbiter.sv
// Testbench for vx_mux_arbiter.
// Three instances: N=4, N=3 and N=1, all with DATAW=8.
// Inputs change shortly after each rising edge. Outputs are sampled on the
// falling edge.
// A reference model predicts grants and ready_in for every instance. Each
// expected {sel,data} is queued at its input handshake and compared when the
// output word is consumed.

module tb_vx_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [3:0]  vi [3];
    logic [31:0] di [3];
    logic        ro [3];

    logic [3:0]  ri0;
    logic [2:0]  ri1;
    logic [0:0]  ri2;
    logic        vo0, vo1, vo2;
    logic [7:0]  do0, do1, do2;
    logic [1:0]  so0, so1;
    logic [0:0]  so2;

    logic [3:0]  ri   [3];
    logic        vo   [3];
    logic [7:0]  dout [3];
    logic [1:0]  so   [3];

    int tests = 0;
    int fails = 0;

    // reference model state
    int          nn      [3];
    int          m_ptr   [3];
    bit          m_valid [3];
    logic [9:0]  sbq     [3][$];

    int          g_m, idx_m;
    bit          found_m, ld_m;
    logic [3:0]  er_m;
    logic [9:0]  exp_m;

    assign ri[0] = ri0;
    assign ri[1] = {1'b0, ri1};
    assign ri[2] = {3'b000, ri2};
    assign vo[0] = vo0;
    assign vo[1] = vo1;
    assign vo[2] = vo2;
    assign dout[0] = do0;
    assign dout[1] = do1;
    assign dout[2] = do2;
    assign so[0] = so0;
    assign so[1] = so1;
    assign so[2] = {1'b0, so2};

    always #5 clk = ~clk;

    vx_mux_arbiter #(.DATAW(8), .N(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .valid_in(vi[0]), .data_in(di[0]),
        .ready_in(ri0), .valid_out(vo0), .data_out(do0), .sel_out(so0), .ready_out(ro[0])
    );

    vx_mux_arbiter #(.DATAW(8), .N(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .valid_in(vi[1][2:0]), .data_in(di[1][23:0]),
        .ready_in(ri1), .valid_out(vo1), .data_out(do1), .sel_out(so1), .ready_out(ro[1])
    );

    vx_mux_arbiter #(.DATAW(8), .N(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .valid_in(vi[2][0:0]), .data_in(di[2][7:0]),
        .ready_in(ri2), .valid_out(vo2), .data_out(do2), .sel_out(so2), .ready_out(ro[2])
    );

    // Reset clears the model and drops every in-flight expected word.
    always @(negedge reset_n) begin
        for (int c = 0; c < 3; c++) begin
            m_ptr[c]   = 0;
            m_valid[c] = 1'b0;
            sbq[c].delete();
        end
    end

    // Reference model and scoreboard, evaluated once per cycle for the coming edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int c = 0; c < 3; c++) begin
                tests++;
                if (vo[c] !== m_valid[c]) begin
                    fails++;
                    $display("FAIL sb_valid[%0d]: got %b expected %b", c, vo[c], m_valid[c]);
                end
                if (m_valid[c] && ro[c]) begin
                    tests++;
                    if (sbq[c].size() == 0) begin
                        fails++;
                        $display("FAIL sb_extra[%0d]: got word sel=%h data=%h expected none", c, so[c], dout[c]);
                    end else begin
                        exp_m = sbq[c].pop_front();
                        if ({so[c], dout[c]} !== exp_m) begin
                            fails++;
                            $display("FAIL sb_word[%0d]: got sel=%h data=%h expected sel=%h data=%h",
                                     c, so[c], dout[c], exp_m[9:8], exp_m[7:0]);
                        end
                    end
                end
                found_m = 1'b0;
                g_m     = 0;
                for (int k = 0; k < nn[c]; k++) begin
                    idx_m = (m_ptr[c] + k) % nn[c];
                    if (!found_m && vi[c][idx_m]) begin
                        found_m = 1'b1;
                        g_m     = idx_m;
                    end
                end
                ld_m = !m_valid[c] || ro[c];
                er_m = (ld_m && found_m) ? (4'd1 << g_m) : 4'd0;
                tests++;
                if (ri[c] !== er_m) begin
                    fails++;
                    $display("FAIL sb_ready_in[%0d]: got %b expected %b", c, ri[c], er_m);
                end
                if (ld_m) begin
                    if (found_m) begin
                        sbq[c].push_back({g_m[1:0], di[c][g_m*8 +: 8]});
                        m_valid[c] = 1'b1;
                        m_ptr[c]   = (g_m + 1) % nn[c];
                    end else begin
                        m_valid[c] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            vi[c] = 4'd0;
            ro[c] = 1'b1;
        end
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({vo0, vo1, vo2} !== 3'b000 || do0 !== 8'h00 || so0 !== 2'd0 || so1 !== 2'd0 || so2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got vo=%b%b%b d0=%h s0=%h expected all zero", vo0, vo1, vo2, do0, so0);
        end
        vi[0] = 4'hF;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ri0 !== 4'b0001 || vo0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_grant: got ri=%b vo=%b expected 0001 0", ri0, vo0);
        end
        @(negedge clk);
        tests++;
        if (vo0 !== 1'b1 || do0 !== 8'hA0 || so0 !== 2'd0) begin
            fails++;
            $display("FAIL reset_first_word: got vo=%b d=%h s=%0d expected 1 a0 0", vo0, do0, so0);
        end
        @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (vo0 !== 1'b0 || do0 !== 8'h00 || so0 !== 2'd0 || u_dut4.rr_ptr_r !== 2'd0) begin
            fails++;
            $display("FAIL reset_async: got vo=%b d=%h s=%0d ptr=%0d expected 0 00 0 0",
                     vo0, do0, so0, u_dut4.rr_ptr_r);
        end
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ri0 !== 4'b0001 || vo0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_regrant: got ri=%b vo=%b expected 0001 0", ri0, vo0);
        end
        @(negedge clk);
        tests++;
        if (do0 !== 8'hA0 || so0 !== 2'd0) begin
            fails++;
            $display("FAIL reset_after_word: got d=%h s=%0d expected a0 0", do0, so0);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] ed;
        logic [1:0] es;
        logic [3:0] er;
        do_reset();
        vi[0] = 4'hF;
        @(negedge clk);
        tests++;
        if (ri0 !== 4'b0001) begin
            fails++;
            $display("FAIL rr_first_ready: got %b expected 0001", ri0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            es = 2'(i % 4);
            ed = 8'hA0 + {6'd0, es};
            er = 4'd1 << ((i + 1) % 4);
            tests++;
            if (vo0 !== 1'b1 || do0 !== ed || so0 !== es || ri0 !== er) begin
                fails++;
                $display("FAIL rr_seq[%0d]: got d=%h s=%0d ri=%b expected d=%h s=%0d ri=%b",
                         i, do0, so0, ri0, ed, es, er);
            end
        end
    endtask

    task automatic test_skip_wrap;
        logic [1:0] es;
        logic [1:0] ep;
        do_reset();
        vi[0] = 4'b1010;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            es = (i % 2 == 0) ? 2'd1 : 2'd3;
            ep = (es == 2'd3) ? 2'd0 : 2'd2;
            tests++;
            if (so0 !== es || do0 !== (8'hA0 + {6'd0, es}) || u_dut4.rr_ptr_r !== ep) begin
                fails++;
                $display("FAIL skip_wrap[%0d]: got s=%0d d=%h ptr=%0d expected s=%0d ptr=%0d",
                         i, so0, do0, u_dut4.rr_ptr_r, es, ep);
            end
        end
        do_reset();
        vi[1] = 4'b0111;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            es = 2'(i % 3);
            tests++;
            if (vo1 !== 1'b1 || so1 !== es || do1 !== (8'hA0 + {6'd0, es})) begin
                fails++;
                $display("FAIL n3_wrap[%0d]: got s=%0d d=%h expected s=%0d", i, so1, do1, es);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        vi[0] = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        ro[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (vo0 !== 1'b1 || do0 !== 8'hA2 || so0 !== 2'd2 || ri0 !== 4'b0000) begin
                fails++;
                $display("FAIL bp_stall[%0d]: got vo=%b d=%h s=%0d ri=%b expected 1 a2 2 0000",
                         k, vo0, do0, so0, ri0);
            end
        end
        @(posedge clk);
        #2;
        ro[0] = 1'b1;
        @(negedge clk);
        tests++;
        if (ri0 !== 4'b1000 || do0 !== 8'hA2) begin
            fails++;
            $display("FAIL bp_release: got ri=%b d=%h expected 1000 a2", ri0, do0);
        end
        @(negedge clk);
        tests++;
        if (do0 !== 8'hA3 || so0 !== 2'd3) begin
            fails++;
            $display("FAIL bp_next: got d=%h s=%0d expected a3 3", do0, so0);
        end
    endtask

    task automatic test_idle_drain;
        do_reset();
        vi[0] = 4'b0010;
        @(negedge clk);
        tests++;
        if (ri0 !== 4'b0010 || vo0 !== 1'b0) begin
            fails++;
            $display("FAIL drain_ready: got ri=%b vo=%b expected 0010 0", ri0, vo0);
        end
        @(posedge clk);
        #2;
        vi[0] = 4'b0000;
        @(negedge clk);
        tests++;
        if (vo0 !== 1'b1 || do0 !== 8'hA1 || so0 !== 2'd1) begin
            fails++;
            $display("FAIL drain_word: got vo=%b d=%h s=%0d expected 1 a1 1", vo0, do0, so0);
        end
        @(negedge clk);
        tests++;
        if (vo0 !== 1'b0 || u_dut4.rr_ptr_r !== 2'd2) begin
            fails++;
            $display("FAIL drain_empty: got vo=%b ptr=%0d expected 0 2", vo0, u_dut4.rr_ptr_r);
        end
        @(negedge clk);
        tests++;
        if (vo0 !== 1'b0) begin
            fails++;
            $display("FAIL drain_stay_empty: got vo=%b expected 0", vo0);
        end
    endtask

    task automatic test_n1_passthrough;
        do_reset();
        vi[2] = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            ro[2] = 1'($urandom_range(0, 1));
            di[2] = {24'd0, 8'($urandom)};
            @(negedge clk);
            tests++;
            if (so2 !== 1'b0 || u_dut1.rr_ptr_r !== 1'b0) begin
                fails++;
                $display("FAIL n1_sel[%0d]: got s=%0d ptr=%0d expected 0 0", i, so2, u_dut1.rr_ptr_r);
            end
        end
        @(posedge clk);
        #2;
        vi[2] = 4'b0000;
        ro[2] = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (sbq[2].size() != 0 || vo2 !== 1'b0) begin
            fails++;
            $display("FAIL n1_drained: got pending=%0d vo=%b expected 0 0", sbq[2].size(), vo2);
        end
    endtask

    task automatic test_all_drained;
        @(posedge clk);
        #2;
        for (int c = 0; c < 3; c++) begin
            vi[c] = 4'd0;
            ro[c] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (sbq[c].size() != 0 || vo[c] !== 1'b0) begin
                fails++;
                $display("FAIL final_drain[%0d]: got pending=%0d vo=%b expected 0 0", c, sbq[c].size(), vo[c]);
            end
        end
    endtask

    initial begin
        nn[0] = 4;
        nn[1] = 3;
        nn[2] = 1;
        reset_n = 1'b0;
        di[0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        di[1] = {8'h00, 8'hA2, 8'hA1, 8'hA0};
        di[2] = {24'd0, 8'h5A};
        for (int c = 0; c < 3; c++) begin
            vi[c] = 4'd0;
            ro[c] = 1'b1;
        end
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_idle_drain();
        test_n1_passthrough();
        test_all_drained();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vx_mux_arbiter.md
# vx_mux_arbiter

Round-robin arbiter and registered output stage that shares one N:1 data multiplexer between N valid/ready requesters. Each cycle it picks one valid requester, drives the mux select, and captures the selected word into a one-entry output register with a valid/ready handshake. It sits in front of shared datapath resources (memory ports, writeback, issue slots) where several streams contend for one consumer.

## Interface
- DATAW, 1, payload width in bits
- N, 1, number of requesters (≥1)
- LN, $clog2(N), select width; physical select ports are SELW = max(LN,1) bits wide
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- valid_in  input  N  per-requester request valid
- data_in  input  N×DATAW  per-requester payload, requester i at bits [i*DATAW +: DATAW]
- ready_in  output  N  per-requester accept; at most one bit high per cycle
- valid_out  output  1  output register holds a word
- data_out  output  DATAW  registered payload
- sel_out  output  SELW  index of the requester whose word is in the output register
- ready_out  input  1  consumer accepts the output word

## Operation
- One clock; reset is asynchronous and active-low: reset_n low forces all state immediately, regardless of clk.
- State: output register (valid_r, data_r, sel_r), round-robin pointer rr_ptr (SELW bits, range 0..N-1).
- load_en = ~valid_r | ready_out (register empty or draining this cycle).
- Grant: first i with valid_in[i] = 1 scanning rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1 (modulo N). No valid bit → no grant.
- ready_in[i] = load_en & grant_valid & (grant == i); combinational from valid_in, rr_ptr, valid_r, ready_out. No other ready_in bit is ever high.
- On clock edge with load_en & grant_valid: data_r ← data_in[grant] (via the mux), sel_r ← grant, valid_r ← 1, rr_ptr ← (grant == N-1) ? 0 : grant+1.
- On edge with load_en & ~grant_valid: valid_r ← 0; data_r, sel_r, rr_ptr hold.
- On edge with ~load_en (valid_r & ~ready_out): everything holds; data_out and sel_out stable.
- rr_ptr advances only on a transfer; it never reaches N (wraps N-1→0 explicitly, including non-power-of-2 N).
- N == 1: grant = 0 whenever valid_in[0]; rr_ptr and sel_r constant 0; behaves as a one-entry pipeline register.
- Requesters may drop valid_in without handshake; arbitration is re-evaluated every cycle (no lock across cycles while stalled; ready_in is low during stall).
- Fairness: a continuously valid requester is granted within N transfers.

## Timing
- Reset values: valid_out 0, data_out 0, sel_out 0, rr_ptr 0; ready_in follows combinationally (= grant to lowest valid index after reset, since register empty).
- Latency: input handshake at edge k → valid_out high with that word from cycle k+1.
- Throughput: 1 word/cycle when ready_out held high (simultaneous drain and load in same cycle).
- Backpressure: ready_out low with valid_out high → all ready_in low next evaluation, output stable until accepted.
- Combinational path ready_out → ready_in exists (documented; not registered).
- Reset asserted mid-transfer: output word dropped, valid_out falls immediately, rr_ptr returns to 0; no handshake completes on that edge.

## Test plan
- Reset: N=4, DATAW=8, pulse reset_n low between edges → valid_out, data_out, sel_out drop to 0 asynchronously; first cycle after release with valid_in=4'b1111 grants requester 0.
- Round-robin: N=4, valid_in=4'b1111 constant, data_in[i]=8'hA0+i, ready_out=1 → data_out sequence A0,A1,A2,A3,A0 on consecutive cycles, sel_out 0,1,2,3,0, one ready_in bit per cycle.
- Skip and wrap: valid_in=4'b1010 continuous, ready_out=1 → grants 1,3,1,3; after grant 3 rr_ptr=0; N=3 with all valid → sel_out 0,1,2,0 (no index 3).
- Backpressure: fill register with A2, hold ready_out=0 for 5 cycles → data_out=A2, sel_out=2 stable, ready_in=0 all cycles; raise ready_out → A3 loads next cycle, no word lost or duplicated.
- Idle drain: single word from requester 1 then valid_in=0, ready_out=1 → valid_out high exactly one cycle, then 0 with rr_ptr=2.
- N=1 pass-through: valid_in=1, random ready_out → output words match input order, sel_out always 0, scoreboard shows no drops.
